// File: rtl/sum35_pkg.sv
// Shared constants and helpers for the multiples-of-3/5 summing datapath.
//   W      : width of counters, accumulator and result
//   IN_W   : width of the exclusive upper bound operand
//   STEPn  : stride of each multiple counter
package sum35_pkg;

  localparam int unsigned W      = 32;
  localparam int unsigned IN_W   = 16;
  localparam int unsigned STEP3  = 3;
  localparam int unsigned STEP5  = 5;
  localparam int unsigned STEP15 = 15;

  // Candidate next multiple and whether it stays strictly below the bound.
  typedef struct packed {
    logic         ok;
    logic [W-1:0] val;
  } next_mult_t;

  // Guarded next-multiple evaluation; the bound is zero-extended to W bits.
  function automatic next_mult_t next_multiple(input logic [W-1:0]    count,
                                               input logic [W-1:0]    step,
                                               input logic [IN_W-1:0] limit);
    next_mult_t r;
    r.val = count + step;
    r.ok  = (r.val < W'(limit));
    return r;
  endfunction

endpackage

// File: rtl/sum35_datapath_if.sv
// Bus between the multiples-of-3/5 control FSM (master) and the datapath (slave).
//   in                 : exclusive upper bound, stable while busy
//   RCn / SCn          : clear / step request for counter n
//   ROut / SOut        : accumulator clear / accumulate enable
//   busy, ack          : FSM busy flag, consumer result acknowledge
//   C3, C5, C15, acc   : counter and accumulator feedback
//   result, result_valid, done, overrun : result handshake
interface sum35_datapath_if;
  import sum35_pkg::*;

  logic [IN_W-1:0] in;
  logic            RC3, RC5, RC15;
  logic            SC3, SC5, SC15;
  logic            ROut, SOut;
  logic            busy;
  logic            ack;
  logic [W-1:0]    C3, C5, C15;
  logic [W-1:0]    acc;
  logic [W-1:0]    result;
  logic            result_valid;
  logic            done;
  logic            overrun;

  modport master (
    output in, RC3, RC5, RC15, SC3, SC5, SC15, ROut, SOut, busy, ack,
    input  C3, C5, C15, acc, result, result_valid, done, overrun
  );

  modport slave (
    input  in, RC3, RC5, RC15, SC3, SC5, SC15, ROut, SOut, busy, ack,
    output C3, C5, C15, acc, result, result_valid, done, overrun
  );

endinterface

// File: rtl/sum35_datapath_step_counter.sv
// Guarded multiple counter: advances by STEP only while the next value stays
// strictly below the bound.
//   clk, rst_n  : clock, async active-low reset
//   clr_i       : synchronous clear, wins over step_i
//   step_i      : step request
//   limit_i     : exclusive bound
//   count_o     : registered current multiple
//   stepped_c_o : combinational, high in the cycle a step is accepted
module step_counter
  import sum35_pkg::*;
#(
  parameter int unsigned STEP = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            step_i,
  input  logic [IN_W-1:0] limit_i,
  output logic [W-1:0]    count_o,
  output logic            stepped_c_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  next_mult_t   nm;

  // Next-count selection: clear, guarded step, or hold.
  always_comb begin
    nm          = next_multiple(count_q, W'(STEP), limit_i);
    count_d     = count_q;
    stepped_c_o = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (step_i && nm.ok) begin
      count_d     = nm.val;
      stepped_c_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sum35_datapath.sv
// Datapath for summing all multiples of 3 or 5 below an operand: three guarded
// multiple counters, an inclusion-exclusion accumulator, and a result register
// captured on the busy falling edge with a valid/ack handshake.
//   clk, rst_n : clock, async active-low reset
//   dp         : slave side of the FSM/consumer bus
module sum35_datapath
  import sum35_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  sum35_datapath_if.slave  dp
);

  logic [W-1:0] c3, c5, c15;
  logic         step3, step5, step15;

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] result_q, result_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;
  logic         overrun_q, overrun_d;
  logic         busy_q;

  logic [W-1:0] add3, add5, sub15;
  logic         capture;

  step_counter #(.STEP(STEP3)) u_cnt3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (dp.RC3),
    .step_i      (dp.SC3),
    .limit_i     (dp.in),
    .count_o     (c3),
    .stepped_c_o (step3)
  );

  step_counter #(.STEP(STEP5)) u_cnt5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (dp.RC5),
    .step_i      (dp.SC5),
    .limit_i     (dp.in),
    .count_o     (c5),
    .stepped_c_o (step5)
  );

  step_counter #(.STEP(STEP15)) u_cnt15 (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (dp.RC15),
    .step_i      (dp.SC15),
    .limit_i     (dp.in),
    .count_o     (c15),
    .stepped_c_o (step15)
  );

  // Terms use pre-update counter values; multiples of 15 are counted twice
  // by the 3 and 5 paths, so the 15 path removes one copy.
  always_comb begin
    add3  = (dp.SOut && step3) ? (c3 + W'(STEP3)) : '0;
    add5  = (dp.SOut && step5) ? (c5 + W'(STEP5)) : '0;
    sub15 = step15 ? (c15 + W'(STEP15)) : '0;
    acc_d = dp.ROut ? '0 : (acc_q + add3 + add5 - sub15);
  end

  assign capture = busy_q & ~dp.busy;

  // Result capture and handshake; a capture overrides a coincident ack.
  always_comb begin
    result_d  = result_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    if (capture) begin
      result_d = acc_q;
      valid_d  = 1'b1;
      done_d   = 1'b1;
      if (valid_q && !dp.ack) begin
        overrun_d = 1'b1;
      end
    end else if (dp.ack && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      busy_q    <= dp.busy;
    end
  end

  assign dp.C3           = c3;
  assign dp.C5           = c5;
  assign dp.C15          = c15;
  assign dp.acc          = acc_q;
  assign dp.result       = result_q;
  assign dp.result_valid = valid_q;
  assign dp.done         = done_q;
  assign dp.overrun      = overrun_q;

endmodule

// File: tb/tb_sum35_datapath.sv
// Bench for sum35_datapath: directed scenarios plus random operands, checked
// against closed-form sums of multiples below the operand.
module tb_sum35_datapath;
  import sum35_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  sum35_datapath_if bus ();

  sum35_datapath dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dp    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Sum of i < n with i a multiple of 3 (if m3) or of 5 (if m5).
  function automatic int unsigned ref_sum(input int unsigned n, input bit m3, input bit m5);
    int unsigned s;
    s = 0;
    for (int unsigned i = 1; i < n; i++) begin
      if ((m3 && (i % 3 == 0)) || (m5 && (i % 5 == 0))) s += i;
    end
    return s;
  endfunction

  // Largest multiple of k strictly below n (0 if none).
  function automatic int unsigned last_mult(input int unsigned n, input int unsigned k);
    return (n == 0) ? 0 : ((n - 1) / k) * k;
  endfunction

  task automatic clear_strobes();
    bus.RC3 = 1'b0; bus.RC5 = 1'b0; bus.RC15 = 1'b0;
    bus.SC3 = 1'b0; bus.SC5 = 1'b0; bus.SC15 = 1'b0;
    bus.ROut = 1'b0; bus.SOut = 1'b0;
  endtask

  // Emulates the control FSM: load, step 3s, step 5s, subtract 15s, drop busy.
  // Each phase requests one extra step to exercise the bound guard.
  task automatic do_run(input int unsigned n, input bit ack_cap);
    int unsigned peak;
    int unsigned total;
    peak  = ref_sum(n, 1'b1, 1'b0) + ref_sum(n, 1'b0, 1'b1);
    total = ref_sum(n, 1'b1, 1'b1);
    bus.in = IN_W'(n);
    bus.busy = 1'b1;
    bus.RC3 = 1'b1; bus.RC5 = 1'b1; bus.RC15 = 1'b1; bus.ROut = 1'b1;
    tick();
    clear_strobes();
    if (n >= 3) begin
      bus.SOut = 1'b1;
      bus.SC3 = 1'b1;
      repeat (last_mult(n, 3) / 3 + 1) tick();
      bus.SC3 = 1'b0;
      bus.SC5 = 1'b1;
      repeat (last_mult(n, 5) / 5 + 1) tick();
      bus.SC5 = 1'b0;
      bus.SOut = 1'b0;
      chk($sformatf("acc_peak[in=%0d]", n), bus.acc, W'(peak));
      bus.SC15 = 1'b1;
      repeat (last_mult(n, 15) / 15 + 1) tick();
      bus.SC15 = 1'b0;
    end
    chk($sformatf("C3[in=%0d]", n),  bus.C3,  W'(last_mult(n, 3)));
    chk($sformatf("C5[in=%0d]", n),  bus.C5,  W'(last_mult(n, 5)));
    chk($sformatf("C15[in=%0d]", n), bus.C15, W'(last_mult(n, 15)));
    chk($sformatf("acc_final[in=%0d]", n), bus.acc, W'(total));
    bus.busy = 1'b0;
    bus.ack = ack_cap;
    tick();
    bus.ack = 1'b0;
    chk($sformatf("done_pulse[in=%0d]", n), W'(bus.done), W'(1));
    chk($sformatf("result[in=%0d]", n), bus.result, W'(total));
    chk($sformatf("valid[in=%0d]", n), W'(bus.result_valid), W'(1));
    tick();
    chk($sformatf("done_low[in=%0d]", n), W'(bus.done), W'(0));
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("valid_after_ack", W'(bus.result_valid), W'(0));
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.in = '0;
    bus.busy = 1'b0;
    bus.ack = 1'b0;
    clear_strobes();
    #12;
    chk("rst_acc", bus.acc, W'(0));
    chk("rst_C3", bus.C3, W'(0));
    chk("rst_valid", W'(bus.result_valid), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    rst_n = 1'b1;
    tick();

    // Basic run; result must stay valid until acknowledged.
    do_run(10, 1'b0);
    repeat (3) tick();
    chk("valid_held", W'(bus.result_valid), W'(1));
    chk("result_held", bus.result, W'(23));
    do_ack();
    chk("no_overrun", W'(bus.overrun), W'(0));

    do_run(16, 1'b0);
    do_ack();

    // Unacknowledged result followed by a new capture raises sticky overrun.
    do_run(1000, 1'b0);
    chk("result_1000", bus.result, W'(233168));
    do_run(10, 1'b0);
    chk("overrun_set", W'(bus.overrun), W'(1));
    do_ack();
    tick();
    chk("overrun_sticky", W'(bus.overrun), W'(1));

    // Asynchronous reset mid-operation with C3=9, acc=23.
    bus.in = IN_W'(10);
    bus.busy = 1'b1;
    bus.RC3 = 1'b1; bus.RC5 = 1'b1; bus.RC15 = 1'b1; bus.ROut = 1'b1;
    tick();
    clear_strobes();
    bus.SOut = 1'b1; bus.SC3 = 1'b1;
    repeat (3) tick();
    bus.SC3 = 1'b0; bus.SC5 = 1'b1;
    tick();
    chk("mid_C3", bus.C3, W'(9));
    chk("mid_acc", bus.acc, W'(23));
    rst_n = 1'b0;
    #1;
    chk("arst_C3", bus.C3, W'(0));
    chk("arst_C5", bus.C5, W'(0));
    chk("arst_acc", bus.acc, W'(0));
    chk("arst_result", bus.result, W'(0));
    chk("arst_overrun", W'(bus.overrun), W'(0));
    clear_strobes();
    bus.busy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", W'(bus.result_valid), W'(0));

    // Early termination below 3.
    do_run(2, 1'b0);
    do_ack();

    // Corner strobes: clear vs step, accumulator clear vs accumulate.
    bus.in = IN_W'(10);
    bus.busy = 1'b1;
    bus.RC3 = 1'b1; bus.RC5 = 1'b1; bus.RC15 = 1'b1; bus.ROut = 1'b1;
    tick();
    clear_strobes();
    bus.SC3 = 1'b1; bus.SOut = 1'b1;
    repeat (2) tick();
    chk("corner_C3_6", bus.C3, W'(6));
    chk("corner_acc_9", bus.acc, W'(9));
    bus.RC3 = 1'b1;
    tick();
    bus.RC3 = 1'b0;
    chk("rc3_wins_C3", bus.C3, W'(0));
    chk("rc3_wins_acc", bus.acc, W'(9));
    bus.ROut = 1'b1;
    tick();
    clear_strobes();
    chk("rout_wins_acc", bus.acc, W'(0));
    chk("rout_C3_steps", bus.C3, W'(3));
    bus.busy = 1'b0;
    tick();
    chk("corner_result", bus.result, W'(0));
    chk("corner_valid", W'(bus.result_valid), W'(1));

    // Capture coincident with ack: new result stays valid, no overrun.
    do_run(16, 1'b1);
    chk("cap_ack_overrun", W'(bus.overrun), W'(0));
    do_ack();

    // Random operands.
    for (int r = 0; r < 6; r++) begin
      int unsigned n;
      n = $urandom_range(0, 700);
      do_run(n, 1'b0);
      do_ack();
      chk($sformatf("rand_overrun[%0d]", r), W'(bus.overrun), W'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sum35_datapath.md
Name: sum35_datapath

Overview:
- Datapath stage directly downstream of the multiples-of-3/5 control FSM. It consumes the FSM's clear/step strobes and operand `in`, and maintains the three multiple counters C3, C5 and C15, which it feeds back to the FSM.
- It accumulates the sum of all multiples of 3 or 5 strictly below `in`, adding multiples of 3 and 5 and subtracting multiples of 15.
- On the FSM's busy falling edge it registers the final sum and presents it with a valid/ack result handshake.

Parameters:
- W, 32, width of counters, accumulator and result.
- IN_W, 16, width of operand `in`.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in  in  IN_W  upper bound (exclusive); upstream holds it stable while busy=1.
- RC3, RC5, RC15  in  1 each  synchronous clear of C3, C5, C15.
- SC3, SC5, SC15  in  1 each  step request for C3, C5, C15.
- ROut  in  1  synchronous clear of accumulator.
- SOut  in  1  enables adding C3/C5 steps into accumulator.
- busy  in  1  FSM busy flag; falling edge marks end of operation.
- ack  in  1  consumer acknowledges result.
- C3, C5, C15  out  W each  current multiple values, fed back to FSM.
- acc  out  W  running accumulator.
- result  out  W  latched final sum.
- result_valid  out  1  result held, awaiting ack.
- done  out  1  one-cycle pulse when result is captured.
- overrun  out  1  sticky: new result captured while previous result unacknowledged.

Behaviour:
- Reset (rst_n=0, async): C3, C5, C15, acc, result, busy_q → 0; result_valid, done, overrun → 0.
- All other state updates happen on the rising edge of clk.
- Zero-extend `in` to W bits for all comparisons.
- Counter n ∈ {3, 5, 15}:
  - RCn=1 → Cn<=0. Clear wins over SCn.
  - Else SCn=1 and (Cn+n) < in → Cn<=Cn+n, and stepn=1 for this cycle.
  - Else Cn holds and stepn=0. The guard means counters never reach or pass `in`.
- Accumulator:
  - ROut=1 → acc<=0. Clear wins over everything, including simultaneous steps.
  - Else acc <= acc + (SOut & step3 ? C3+3 : 0) + (SOut & step5 ? C5+5 : 0) − (step15 ? C15+15 : 0).
  - The terms are evaluated with pre-update counter values. All three terms may apply in the same cycle.
  - Arithmetic is modulo 2^W. W=32 is sufficient for IN_W=16 (maximum sum is about 1.0e9), so no overflow detection is required.
- End-of-operation capture:
  - busy_q<=busy every cycle.
  - Capture condition: busy_q=1 and busy=0.
  - On capture: result<=acc, result_valid<=1, done<=1. done is high for exactly that one cycle, otherwise 0.
  - If result_valid=1 and ack=0 at the capture edge, set overrun<=1. overrun is sticky until reset.
- Handshake:
  - ack=1 with result_valid=1 and no capture → result_valid<=0.
  - Capture and ack in the same cycle → capture wins; result_valid stays 1 with the new result, and no overrun is raised.
  - ack with result_valid=0 is ignored.
- Latency: a step is visible on Cn/acc one cycle after its strobe; result/done appear one cycle after busy is first sampled low.
- Early termination: the FSM drops busy straight from its load state when in<3. Accumulator was cleared by ROut, so result=0.
- Reset mid-operation: all state returns to reset values immediately; any pending result is lost.

Decomposition:
- Package sum35_pkg:
  - constants W, IN_W, and STEP3=3, STEP5=5, STEP15=15;
  - a function for guarded next-multiple evaluation.
- Sub-module step_counter, parameter STEP:
  - inputs clk, rst_n, clr, step, limit;
  - outputs count and stepped.
  - Instantiate three times; the accumulator and handshake logic stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-run with C3=9, acc=23 → all outputs 0 immediately, with no clock edge required.
- in=10, drive the FSM strobe sequence to completion → C3 stops at 9, C5 at 5; result=23; one-cycle done; result_valid=1 until ack.
- in=16 → acc peaks at 75 (3+6+9+12+15+5+10+15), the SC15 cycle subtracts 15, result=60.
- in=1000 full run → result=233168. Hold ack=0 and start a second run with in=10 → result=23, overrun=1 (sticky).
- in=2 → FSM drops busy straight from its load state; result=0, done pulses, counters remain 0.
- Corner strobes: RC3 with SC3 → C3=0; ROut with SC3/SOut → acc=0; capture coincident with ack → result_valid stays 1, overrun stays 0.
